// File: rtl/video_layer_mixer.sv
// Mixes LAYERS one-bit video layers through per-layer palettes into a saturated RGB pixel.
// Two ce_pix-qualified pipeline stages; colour mode and inversion latch on vs rising edges.
module video_layer_mixer #(
  parameter int LAYERS = 3,
  parameter int CW     = 4
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ce_pix,
  input  logic [LAYERS-1:0]   layer,
  input  logic                inv_layer,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                blank_in,
  input  logic                color_sel,
  input  logic [1:0]          inv_mode,
  input  logic                pal_we,
  input  logic                pal_set,
  input  logic [2:0]          pal_idx,
  input  logic [3*CW-1:0]     pal_data,
  output logic [CW-1:0]       r_out,
  output logic [CW-1:0]       g_out,
  output logic [CW-1:0]       b_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                de_out
);

  localparam int SW = CW + 3;
  localparam logic [CW-1:0] PAL_RST = {1'b0, {(CW-1){1'b1}}};

  typedef logic [3*CW-1:0] rgb_t;

  rgb_t pal_q [2][LAYERS];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < LAYERS; i++)
          pal_q[s][i] <= {3{PAL_RST}};
    end else if (pal_we) begin
      // Indices beyond the layer count simply match no entry.
      for (int i = 0; i < LAYERS; i++)
        if (int'(pal_idx) == i) pal_q[pal_set][i] <= pal_data;
    end
  end

  logic       vs_prev_q, vs_prev_d;
  logic       inv_acc_q, inv_acc_d;
  logic       inv_active_q, inv_active_d;
  logic       mode_cs_q, mode_cs_d;
  logic [1:0] mode_inv_q, mode_inv_d;
  logic       boundary;

  always_comb begin
    vs_prev_d    = vs_prev_q;
    inv_acc_d    = inv_acc_q;
    inv_active_d = inv_active_q;
    mode_cs_d    = mode_cs_q;
    mode_inv_d   = mode_inv_q;
    boundary     = ce_pix && vs_in && !vs_prev_q;
    if (ce_pix) begin
      vs_prev_d = vs_in;
      if (boundary) begin
        case (mode_inv_q)
          2'b01:   inv_active_d = inv_acc_q;
          2'b10:   inv_active_d = 1'b1;
          default: inv_active_d = 1'b0;
        endcase
        // The boundary-cycle sample starts the new frame's accumulation.
        inv_acc_d  = inv_layer;
        mode_cs_d  = color_sel;
        mode_inv_d = inv_mode;
      end else begin
        inv_acc_d = inv_acc_q | inv_layer;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      vs_prev_q    <= 1'b1;
      inv_acc_q    <= 1'b0;
      inv_active_q <= 1'b0;
      mode_cs_q    <= 1'b0;
      mode_inv_q   <= 2'b00;
    end else begin
      vs_prev_q    <= vs_prev_d;
      inv_acc_q    <= inv_acc_d;
      inv_active_q <= inv_active_d;
      mode_cs_q    <= mode_cs_d;
      mode_inv_q   <= mode_inv_d;
    end
  end

  logic [LAYERS-1:0] layer_q;
  logic              hs1_q, vs1_q, blank1_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      layer_q  <= '0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      blank1_q <= 1'b0;
    end else if (ce_pix) begin
      layer_q  <= layer;
      hs1_q    <= hs_in;
      vs1_q    <= vs_in;
      blank1_q <= blank_in;
    end
  end

  function automatic logic [CW-1:0] sat(input logic [SW-1:0] s);
    return (|s[SW-1:CW]) ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  logic [SW-1:0] sum_r, sum_g, sum_b;
  logic [CW-1:0] r_d, g_d, b_d, inv_mask;

  always_comb begin
    sum_r    = '0;
    sum_g    = '0;
    sum_b    = '0;
    inv_mask = {CW{inv_active_q}};
    for (int i = 0; i < LAYERS; i++) begin
      if (layer_q[i]) begin
        sum_r = sum_r + SW'(pal_q[mode_cs_q][i][3*CW-1:2*CW]);
        sum_g = sum_g + SW'(pal_q[mode_cs_q][i][2*CW-1:CW]);
        sum_b = sum_b + SW'(pal_q[mode_cs_q][i][CW-1:0]);
      end
    end
    r_d = blank1_q ? '0 : (sat(sum_r) ^ inv_mask);
    g_d = blank1_q ? '0 : (sat(sum_g) ^ inv_mask);
    b_d = blank1_q ? '0 : (sat(sum_b) ^ inv_mask);
  end

  logic [CW-1:0] r_q, g_q, b_q;
  logic          hs_q, vs_q, de_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else if (ce_pix) begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs1_q;
      vs_q <= vs1_q;
      de_q <= ~blank1_q;
    end
  end

  assign r_out  = r_q;
  assign g_out  = g_q;
  assign b_out  = b_q;
  assign hs_out = hs_q;
  assign vs_out = vs_q;
  assign de_out = de_q;

endmodule

// File: tb/tb_video_layer_mixer.sv
// Randomised and directed stimulus for video_layer_mixer, checked by a queue-based scoreboard.
module tb_video_layer_mixer;
  localparam int L    = 3;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk_sys = 1'b0;
  logic          reset_n, ce_pix, inv_layer, hs_in, vs_in, blank_in, color_sel;
  logic [L-1:0]  layer;
  logic [1:0]    inv_mode;
  logic          pal_we, pal_set;
  logic [2:0]    pal_idx;
  logic [3*CW-1:0] pal_data;
  logic [CW-1:0] r_out, g_out, b_out;
  logic          hs_out, vs_out, de_out;

  always #5 clk_sys = ~clk_sys;

  video_layer_mixer #(.LAYERS(L), .CW(CW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .layer(layer),
    .inv_layer(inv_layer), .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .color_sel(color_sel), .inv_mode(inv_mode), .pal_we(pal_we), .pal_set(pal_set),
    .pal_idx(pal_idx), .pal_data(pal_data), .r_out(r_out), .g_out(g_out),
    .b_out(b_out), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out)
  );

  typedef struct packed {
    logic [CW-1:0] r, g, b;
    logic          hs, vs, de;
  } out_t;

  typedef struct packed {
    logic [L-1:0] layer;
    logic         hs, vs, blank;
  } pix_t;

  int checks = 0;
  int fails  = 0;

  // Reference model: palette as integer colours, frame state as plain flags,
  // and a queue of pixels that have been sampled but not yet displayed.
  int   pal_m [2][L][3];
  bit   m_cs, m_acc, m_act, m_vsprev;
  int   m_inv;
  pix_t waiting [$];
  out_t exp_q [$];

  function automatic void model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < L; i++)
        for (int c = 0; c < 3; c++) pal_m[s][i][c] = (1 << (CW - 1)) - 1;
    m_cs = 0; m_inv = 0; m_acc = 0; m_act = 0; m_vsprev = 1;
    waiting.delete();
    waiting.push_back('0);
  endfunction

  function automatic out_t show(pix_t p);
    out_t o;
    int v [3];
    for (int c = 0; c < 3; c++) begin
      int s = 0;
      for (int i = 0; i < L; i++) if (p.layer[i]) s += pal_m[m_cs][i][c];
      v[c] = (s > MAXC) ? MAXC : s;
      if (p.blank) v[c] = 0;
      else if (m_act) v[c] = MAXC - v[c];
    end
    o.r = CW'(v[0]); o.g = CW'(v[1]); o.b = CW'(v[2]);
    o.hs = p.hs; o.vs = p.vs; o.de = !p.blank;
    return o;
  endfunction

  // Predicts what the coming clock edge does with the inputs as currently driven.
  function automatic void model_edge();
    if (!reset_n) begin
      model_reset();
      exp_q.push_back('0);
      return;
    end
    if (ce_pix) begin
      pix_t p;
      exp_q.push_back(show(waiting.pop_front()));
      if (vs_in && !m_vsprev) begin
        m_act = (m_inv == 1) ? m_acc : (m_inv == 2);
        m_acc = inv_layer;
        m_cs  = color_sel;
        m_inv = int'(inv_mode);
      end else begin
        m_acc = m_acc | inv_layer;
      end
      m_vsprev = vs_in;
      p.layer = layer; p.hs = hs_in; p.vs = vs_in; p.blank = blank_in;
      waiting.push_back(p);
    end
    if (pal_we && int'(pal_idx) < L) begin
      pal_m[pal_set][int'(pal_idx)][0] = int'(pal_data[3*CW-1:2*CW]);
      pal_m[pal_set][int'(pal_idx)][1] = int'(pal_data[2*CW-1:CW]);
      pal_m[pal_set][int'(pal_idx)][2] = int'(pal_data[CW-1:0]);
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_out(input string name, input int r, input int g, input int b, input bit de);
    out_t want, got;
    want.r = CW'(r); want.g = CW'(g); want.b = CW'(b);
    want.hs = 1'b0; want.vs = 1'b0; want.de = de;
    got = {r_out, g_out, b_out, hs_out, vs_out, de_out};
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got rgb=%0d,%0d,%0d hs=%b vs=%b de=%b, want rgb=%0d,%0d,%0d hs=0 vs=0 de=%b",
               name, got.r, got.g, got.b, got.hs, got.vs, got.de, r, g, b, de);
    end
  endtask

  // One frame: vs high for the boundary cycle, then low; optional inv_layer pulse.
  task automatic frame(input int len, input int pulse, input bit exp_inv, input string name, input bit chk);
    vs_in = 1'b1; inv_layer = (pulse == 0); tick();
    vs_in = 1'b0;
    for (int k = 1; k < len; k++) begin
      inv_layer = (k == pulse);
      tick();
    end
    inv_layer = 1'b0;
    if (chk) check_out(name, exp_inv ? MAXC : 0, exp_inv ? MAXC : 0, exp_inv ? MAXC : 0, 1'b1);
  endtask

  // Monitor: every enabled or reset edge pops one expectation; otherwise outputs must hold.
  out_t last_exp = '0;
  initial begin
    forever begin
      bit c, r;
      out_t got, want;
      @(posedge clk_sys);
      c = ce_pix; r = reset_n;
      @(negedge clk_sys);
      got = {r_out, g_out, b_out, hs_out, vs_out, de_out};
      checks++;
      if (!r || c) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_underflow: output edge with no expectation, got %h", got);
        end else begin
          want = exp_q.pop_front();
          last_exp = want;
          if (got !== want) begin
            fails++;
            $display("FAIL pixel: got %h want %h (r,g,b,hs,vs,de) at %0t", got, want, $time);
          end
        end
      end else if (got !== last_exp) begin
        fails++;
        $display("FAIL hold: got %h want %h while ce_pix low at %0t", got, last_exp, $time);
      end
    end
  end

  initial begin
    reset_n = 0; ce_pix = 1; layer = '0; inv_layer = 0; hs_in = 0; vs_in = 0;
    blank_in = 0; color_sel = 0; inv_mode = 2'b00; pal_we = 0; pal_set = 0;
    pal_idx = '0; pal_data = '0;
    repeat (3) tick();
    check_out("reset_state", 0, 0, 0, 1'b0);
    reset_n = 1;

    layer = 3'b001; repeat (3) tick(); check_out("one_layer", 7, 7, 7, 1'b1);
    layer = 3'b111; repeat (3) tick(); check_out("saturate", 15, 15, 15, 1'b1);
    blank_in = 1;   repeat (3) tick(); check_out("blank", 0, 0, 0, 1'b0);
    blank_in = 0;

    pal_we = 1; pal_set = 1; pal_idx = 3'd1; pal_data = {4'd0, 4'd15, 4'd15}; tick();
    pal_set = 0; pal_idx = 3'd5; pal_data = '0; tick();
    pal_we = 0;
    layer = 3'b010; repeat (3) tick(); check_out("before_edge", 7, 7, 7, 1'b1);
    layer = 3'b011; repeat (3) tick(); check_out("ignored_idx", 14, 14, 14, 1'b1);
    color_sel = 1; vs_in = 1; tick();
    vs_in = 0; layer = 3'b010; repeat (3) tick(); check_out("colour_set", 0, 15, 15, 1'b1);

    layer = '0; inv_mode = 2'b01;
    frame(12, -1, 0, "inv_latch", 1);
    frame(12, 5, 0, "inv_frame_n", 1);
    frame(12, -1, 1, "inv_frame_n1", 1);
    frame(12, -1, 0, "inv_frame_n2", 1);
    frame(12, 0, 0, "pulse_on_boundary", 1);
    frame(12, -1, 1, "boundary_pulse_n2", 1);
    inv_mode = 2'b10;
    frame(12, -1, 0, "forced_latch", 1);
    frame(12, -1, 1, "forced_1", 1);
    frame(12, -1, 1, "forced_2", 1);
    inv_mode = 2'b00;
    frame(12, 3, 1, "off_latch", 1);
    frame(12, 3, 0, "off_1", 1);
    frame(12, 0, 0, "off_2", 1);

    for (int n = 0; n < 400; n++) begin
      ce_pix    = (n % 10 == 0);
      layer     = L'($urandom);
      blank_in  = ($urandom % 4 == 0);
      hs_in     = $urandom_range(0, 1);
      vs_in     = ((n % 53) < 4);
      inv_layer = ($urandom % 8 == 0);
      inv_mode  = 2'($urandom);
      color_sel = $urandom_range(0, 1);
      tick();
    end

    ce_pix = 1; hs_in = 0; blank_in = 0; color_sel = 0; layer = '0; inv_mode = 2'b10;
    frame(12, -1, 0, "pre_reset_a", 0);
    frame(12, -1, 0, "pre_reset_b", 0);
    frame(12, -1, 1, "pre_reset_inv", 1);
    pal_we = 1; pal_set = 0; pal_idx = 3'd0; pal_data = {4'd1, 4'd2, 4'd3}; tick();
    pal_we = 0; layer = 3'b001; repeat (3) tick();
    check_out("mod_pal_inverted", 14, 13, 12, 1'b1);
    reset_n = 0; tick();
    check_out("reset_mid_frame", 0, 0, 0, 1'b0);
    reset_n = 1; repeat (3) tick();
    check_out("post_reset_palette", 7, 7, 7, 1'b1);
    layer = '0;
    frame(12, -1, 0, "post_reset_frame", 1);

    for (int n = 0; n < 1500; n++) begin
      reset_n   = ($urandom % 300 != 0);
      ce_pix    = ($urandom % 4 != 0);
      layer     = L'($urandom);
      blank_in  = ($urandom % 5 == 0);
      hs_in     = ((n % 29) < 3);
      vs_in     = ((n % 97) < 5);
      inv_layer = ($urandom % 16 == 0);
      inv_mode  = 2'($urandom);
      color_sel = $urandom_range(0, 1);
      pal_we    = ($urandom % 6 == 0);
      pal_set   = $urandom_range(0, 1);
      pal_idx   = 3'($urandom);
      pal_data  = (3*CW)'($urandom);
      tick();
    end

    reset_n = 1; pal_we = 0; ce_pix = 0;
    repeat (3) @(negedge clk_sys);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
